// File: rtl/ct_result_drain_pkg.sv
// ct_result_drain_pkg : shared types and helpers for the result-drain block (rev 1.0)
`default_nettype none

`ifndef N
`define N 16
`endif
`ifndef K
`define K 16
`endif

package ct_result_drain_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } ct_drain_state_t;

   // Two spare slots beyond the read latency keep reads streaming while the sink accepts.
   function automatic int fifo_depth(input int rd_lat);
      return rd_lat + 2;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ct_result_drain_bram_if.sv
// DPBRAMInterface : one port of a dual-port BRAM (rev 1.0)
`default_nettype none

interface DPBRAMInterface #(
   parameter int AW = 4,
   parameter int DW = 16
);
   logic          en;
   logic          we;
   logic [AW-1:0] addr;
   logic [DW-1:0] rdata;

   modport reader (output en, output we, output addr, input rdata);
   modport memory (input en, input we, input addr, output rdata);
endinterface

`default_nettype wire

// File: rtl/ct_result_drain_coef_fifo.sv
// coef_fifo : small synchronous FIFO with occupancy count, any depth >= 2 (rev 1.0)
`default_nettype none

module coef_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 3,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
         end
         // Simultaneous push and pop leaves the count unchanged.
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/ct_result_drain.sv
// ct_result_drain : streams {c1_pt[i], c0_pt[i]} out of two BRAMs with credit-based flow control (rev 1.0)
`default_nettype none

module ct_result_drain
   import ct_result_drain_pkg::*;
#(
   parameter int N      = `N,
   parameter int K      = `K,
   parameter int RD_LAT = 1
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   DPBRAMInterface.reader c0_pt_bram,
   DPBRAMInterface.reader c1_pt_bram,
   output logic           m_valid,
   input  logic           m_ready,
   output logic [2*K-1:0] m_data,
   output logic           m_last,
   output logic           done
);
   localparam int DEPTH = fifo_depth(RD_LAT);
   localparam int IW    = (N > 1) ? $clog2(N) : 1;
   localparam int CW    = $clog2(DEPTH + 1);
   localparam int OW    = CW + 1;

   ct_drain_state_t   state;
   logic [IW-1:0]     rd_idx;
   logic [IW-1:0]     beat_idx;
   logic [RD_LAT-1:0] in_flight;
   logic              rd_en;
   logic              pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CW-1:0]     fifo_count;
   logic [2*K-1:0]    fifo_head;
   logic [OW-1:0]     outstanding;

   // Every issued read owns a FIFO slot until the sink takes it.
   always_comb begin
      outstanding = OW'(fifo_count);
      for (int i = 0; i < RD_LAT; i++) begin
         outstanding = outstanding + OW'(in_flight[i]);
      end
   end

   assign m_valid = !fifo_empty;
   assign pop     = m_valid && m_ready;
   assign rd_en   = (state == ST_READ) && !fifo_full
                    && ((outstanding - OW'(pop)) < OW'(DEPTH));
   assign m_data  = m_valid ? fifo_head : '0;
   assign m_last  = m_valid && (beat_idx == IW'(N - 1));

   assign c0_pt_bram.en   = rd_en;
   assign c0_pt_bram.we   = 1'b0;
   assign c0_pt_bram.addr = rd_idx;
   assign c1_pt_bram.en   = rd_en;
   assign c1_pt_bram.we   = 1'b0;
   assign c1_pt_bram.addr = rd_idx;

   coef_fifo #(
      .WIDTH (2 * K),
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (in_flight[RD_LAT-1]),
      .push_data ({c1_pt_bram.rdata, c0_pt_bram.rdata}),
      .pop       (pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= ST_IDLE;
         rd_idx    <= '0;
         beat_idx  <= '0;
         in_flight <= '0;
         done      <= 1'b0;
      end else begin
         in_flight[0] <= rd_en;
         for (int i = 1; i < RD_LAT; i++) begin
            in_flight[i] <= in_flight[i-1];
         end
         if (pop)   beat_idx <= beat_idx + IW'(1);
         if (rd_en) rd_idx   <= rd_idx + IW'(1);

         case (state)
            ST_IDLE: begin
               if (start) begin
                  state    <= ST_READ;
                  rd_idx   <= '0;
                  beat_idx <= '0;
               end
            end
            ST_READ: begin
               if (rd_en && (rd_idx == IW'(N - 1))) state <= ST_FLUSH;
            end
            ST_FLUSH: begin
               if (pop && m_last) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
               end
            end
            ST_DONE: begin
               if (!start) begin
                  state <= ST_IDLE;
                  done  <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: doc/ct_result_drain.md
CT_RESULT_DRAIN -- requirements
Module: ct_result_drain

Interface
REQ-001 SHALL have parameter N, default `N, polynomial length (coefficients per polynomial).
REQ-002 SHALL have parameter K, default `K, coefficient width in bits.
REQ-003 SHALL have parameter RD_LAT, default 1, BRAM read latency in cycles (1..3).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is synchronous to its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous, active-low reset.
REQ-006 SHALL have port start, input, 1, level request to drain both result polynomials.
REQ-007 SHALL have port c0_pt_bram, DPBRAMInterface, read side only, source of c0*pt coefficients.
REQ-008 SHALL have port c1_pt_bram, DPBRAMInterface, read side only, source of c1*pt coefficients.
REQ-009 SHALL have port m_valid, output, 1, the output beat is valid.
REQ-010 SHALL have port m_ready, input, 1, the downstream sink accepts the beat.
REQ-011 SHALL have port m_data, output, 2K, {c1_pt[i], c0_pt[i]}, with c0 in the low K bits.
REQ-012 SHALL have port m_last, output, 1, asserted with the beat for i = N-1.
REQ-013 SHALL have port done, output, 1, drain complete.

Function
REQ-014 SHALL implement states IDLE, READ, FLUSH, DONE.
REQ-015 SHALL move IDLE->READ when start=1, clearing the read address rd_idx and the beat index.
REQ-016 SHALL, in READ, issue one read per cycle at address rd_idx to both BRAMs together (same address, same enable), only when credit is available.
REQ-017 SHALL define credit as (reads in flight + FIFO occupancy) < FIFO depth, with FIFO depth = RD_LAT+2.
REQ-018 SHALL push read data into the FIFO exactly RD_LAT cycles after issue, using a valid shift register, and never drop a word.
REQ-019 SHALL move READ->FLUSH on the cycle the read for rd_idx = N-1 issues.
REQ-020 SHALL move FLUSH->DONE on the cycle the beat with m_last=1 is accepted (m_valid && m_ready).
REQ-021 SHALL hold done=1 in DONE and move DONE->IDLE when start=0; done=0 in every other state.
REQ-022 SHALL drive m_valid as "FIFO non-empty", with m_data and m_last taken from the FIFO head.
REQ-023 SHALL hold m_data and m_last stable while m_valid=1 and m_ready=0.
REQ-024 SHALL achieve one beat per cycle with m_ready held at 1; the first beat appears RD_LAT+1 cycles after entry to READ.
REQ-025 SHALL handle a simultaneous FIFO push and pop in one cycle with occupancy unchanged.
REQ-026 SHALL keep the FIFO from overflowing or underflowing under any m_ready pattern.
REQ-027 SHALL ignore start while in READ or FLUSH, so a drain is never restarted mid-operation.
REQ-028 SHALL drive m_last=1 only on beat index N-1, compared at $clog2(N) bits with no wrap.
REQ-029 SHALL keep BRAM enables deasserted in IDLE, FLUSH and DONE; the module never writes either BRAM.

Reset
REQ-030 SHALL, on reset=0 at a clock edge, go to IDLE and clear m_valid, m_last, done, the BRAM enables, rd_idx, the in-flight shift register and the FIFO pointers.
REQ-031 SHALL drive m_data to 0 on reset.
REQ-032 SHALL abort a drain when reset is applied mid-drain, discarding in-flight data; the next start re-drains from index 0.

Structure
REQ-033 SHALL place the state enum ct_drain_state_t in the shared package; N and K come from params.vh.
REQ-034 SHALL implement the FIFO as one sub-module, coef_fifo (parameters WIDTH, DEPTH), with push, pop, full, empty and count.

Verification
REQ-035 With N=16, RD_LAT=1, m_ready=1, c0_pt[i]=i, c1_pt[i]=100+i: expect 16 beats on consecutive cycles, m_data={100+i,i}, m_last only on beat 15, and done one cycle after.
REQ-036 With m_ready toggled 1,0,0,1 repeating and RD_LAT=2: expect the same 16 beats in order, data stable while stalled, and occupancy never above 4.
REQ-037 With m_ready=0 for 20 cycles after start: expect at most 4 reads issued, m_valid=1 with beat 0 held, and no BRAM enable once credit is exhausted.
REQ-038 With reset=0 applied at beat 7 and then start reasserted: expect the stream to restart at beat 0 with all 16 beats intact.
REQ-039 With start held after done: expect done to stay 1 and no new reads; after start=0 for one cycle, expect IDLE with done=0.
